// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce_sync block.
//   debounce_state_t : 2-bit FSM state encoding (stable / checking levels)
//   GLITCH_W         : width of the optional aborted-check counter
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } debounce_state_t;

  localparam int GLITCH_W = 8;

endpackage : debounce_pkg

// File: rtl/debounce_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
// Parameters:
//   STAGES : number of flops in the chain (2..4)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every flop
//   d     : asynchronous input bit
//   q     : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Synchronizes a bouncing external signal and accepts a level change only after
// DEBOUNCE_CYCLES consecutive synchronized samples of the new level.
// Parameters:
//   SYNC_STAGES     : synchronizer depth (2..4)
//   DEBOUNCE_CYCLES : stable samples needed to accept a change (2..65535)
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   a_raw      : asynchronous, possibly bouncing input
//   a          : debounced level (registered)
//   rise       : one-cycle strobe in the first cycle a reads 1
//   fall       : one-cycle strobe in the first cycle a reads 0
//   glitch_cnt : saturating count of aborted checks; only present when the
//                macro DEBOUNCE_SYNC_GLITCH_CNT_EN is defined
// -----------------------------------------------------------------------------
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_raw,
  output logic                a,
  output logic                rise,
  output logic                fall
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            s;
  debounce_state_t state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic            a_d, rise_d, fall_d;

  // ---- stage 0: synchronizer -------------------------------------------------
  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (a_raw),
    .q    (s)
  );

  // ---- stage 1: debounce FSM -------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // The counter tracks how many consecutive samples of the candidate level have
  // been seen; it restarts at 1 on every check entry and so never wraps.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_LOW: begin
        if (s) begin
          next_state = ST_CHK_HIGH;
          next_cnt   = CNT_ONE;
        end
      end
      ST_CHK_HIGH: begin
        if (!s) begin
          next_state = ST_LOW;
        end else if (cnt == CNT_LAST) begin
          next_state = ST_HIGH;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          next_state = ST_CHK_LOW;
          next_cnt   = CNT_ONE;
        end
      end
      ST_CHK_LOW: begin
        if (s) begin
          next_state = ST_HIGH;
        end else if (cnt == CNT_LAST) begin
          next_state = ST_LOW;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = ST_LOW;
      end
    endcase
  end

  // Outputs are decoded from the next state so that a, rise and fall all change
  // on the same edge that commits the new state.
  always_comb begin
    a_d    = (next_state == ST_HIGH) || (next_state == ST_CHK_LOW);
    rise_d = a_d & ~a;
    fall_d = ~a_d & a;
  end

  // ---- stage 2: registered outputs -------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      a    <= a_d;
      rise <= rise_d;
      fall <= fall_d;
    end
  end

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == {GLITCH_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // A check is aborted when the synchronized input returns to the stable level
  // before the required run of samples completes.
  logic abort;
  assign abort = ((state == ST_CHK_HIGH) && !s) || ((state == ST_CHK_LOW) && s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (abort) begin
      glitch_cnt <= sat_inc(glitch_cnt);
    end
  end
`endif

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
// Scoreboard bench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The stimulus process drives a_raw once per cycle, advances a run-length
// reference model and queues the expected outputs for the coming edge; a
// monitor pops and compares after every rising edge. Glitch-counter checks are
// compiled in when DEBOUNCE_SYNC_GLITCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int SYNC_STAGES = 2;
  localparam int DC          = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic a_raw;
  logic a, rise, fall;
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_raw     (a_raw),
    .a         (a),
    .rise      (rise),
    .fall      (fall)
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  typedef struct packed {
    logic       a;
    logic       rise;
    logic       fall;
    logic [7:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a_raw seen by the debouncer SYNC_STAGES edges late, and a
  // level that flips after DC consecutive samples differing from it.
  bit   hist[$];
  bit   m_lvl;
  int   m_run;
  int   m_glitch;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
    m_lvl    = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endfunction

  function automatic void model_edge(input bit v);
    bit   samp;
    exp_t e;
    samp = hist.pop_front();
    hist.push_back(v);
    e = '0;
    if (samp != m_lvl) begin
      m_run++;
      if (m_run == DC) begin
        m_lvl  = samp;
        m_run  = 0;
        e.rise = samp;
        e.fall = !samp;
      end
    end else begin
      if (m_run > 0 && m_glitch < 255) m_glitch++;
      m_run = 0;
    end
    e.a = m_lvl;
    e.g = 8'(m_glitch);
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit v);
    @(negedge clk);
    a_raw = v;
    model_edge(v);
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) step(v);
  endtask

  task automatic check_reset_outputs();
    check("rst_a", 32'(a), 0);
    check("rst_rise", 32'(rise), 0);
    check("rst_fall", 32'(fall), 0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    check("rst_glitch", 32'(glitch_cnt), 0);
`endif
  endtask

  // Asserts reset mid-cycle (away from any rising edge) for n edges.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    exp_q.push_back('0);
    repeat (n - 1) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
  endtask

  task automatic release_step(input bit v);
    @(negedge clk);
    rst_n = 1'b1;
    a_raw = v;
    model_edge(v);
  endtask

  // Monitor: one queued expectation per rising edge while stimulus runs.
  exp_t got_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        got_e = exp_q.pop_front();
        check("a", 32'(a), 32'(got_e.a));
        check("rise", 32'(rise), 32'(got_e.rise));
        check("fall", 32'(fall), 32'(got_e.fall));
        check("rise_fall_excl", 32'(rise & fall), 0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
        check("glitch_cnt", 32'(glitch_cnt), 32'(got_e.g));
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    a_raw = 1'b1;
    model_reset();
    // Reset with a_raw high: outputs clear without any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
    // Release with a_raw already high: handled as a normal rising change.
    release_step(1'b1);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Clean rise, then clean fall.
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Short high pulse: aborted check, no strobe.
    hold(1'b1, 3);
    hold(1'b0, 8);

    // Bouncing fall from a high level.
    hold(1'b1, 10);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    hold(1'b0, 10);

    // Reset in the middle of a rising check, a_raw stays high across it.
    step(1'b1);
    step(1'b1);
    do_reset(2);
    release_step(1'b1);
    hold(1'b1, 10);

    // Reset while the debounced level is high.
    do_reset(1);
    release_step(1'b0);
    hold(1'b0, 8);

    // Random runs of varying length with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
        release_step(1'(($urandom_range(0, 1))));
      end
      hold(1'(($urandom_range(0, 1))), int'($urandom_range(1, 7)));
    end

    // Many three-cycle glitches drive the counter into saturation.
    hold(1'b0, 10);
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
    hold(1'b0, 5);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    check("glitch_saturated", 32'(glitch_cnt), 255);
`endif
    check("final_level", 32'(a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_debounce_sync

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable synchronized samples required to accept a change (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port a_raw, input, 1 bit: asynchronous, possibly bouncing external signal.
REQ-006 SHALL have port a, output, 1 bit: clean debounced level, which feeds the downstream edge/pulse detectors.
REQ-007 SHALL have port rise, output, 1 bit: one-cycle strobe when a goes 0->1.
REQ-008 SHALL have port fall, output, 1 bit: one-cycle strobe when a goes 1->0.
REQ-009 SHALL have port glitch_cnt, output, 8 bits: present only with DEBOUNCE_SYNC_GLITCH_CNT_EN.

Function
REQ-010 SHALL pass a_raw through a SYNC_STAGES flop chain; the last flop output is s.
REQ-011 SHALL implement a registered FSM with states ST_LOW, ST_CHK_HIGH, ST_HIGH, ST_CHK_LOW, plus a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-012 SHALL, in ST_LOW with s=1, go to ST_CHK_HIGH with cnt=1; with s=0, stay in ST_LOW.
REQ-013 SHALL, in ST_CHK_HIGH with s=0, return to ST_LOW (aborted check); with s=1 and cnt==DEBOUNCE_CYCLES-1, go to ST_HIGH; otherwise increment cnt.
REQ-014 SHALL handle ST_HIGH and ST_CHK_LOW symmetrically with s inverted.
REQ-015 SHALL register output a: 1 in ST_HIGH and ST_CHK_LOW, 0 otherwise.
REQ-016 SHALL make rise and fall registered and asserted in exactly the first cycle a shows its new value, for exactly one cycle; rise and fall are never both 1.
REQ-017 SHALL update a exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples a stable new a_raw value, counting that edge as edge 1.
REQ-018 SHALL leave a unchanged for any a_raw pulse or gap shorter than DEBOUNCE_CYCLES synchronized samples, with no strobe.
REQ-019 SHALL never wrap the counter; it resets to 1 on entry to a check state.

Reset
REQ-020 SHALL, while rst_n=0, immediately force: sync flops 0, state ST_LOW, cnt 0, a=0, rise=0, fall=0, glitch_cnt=0.
REQ-021 SHALL, on reset assertion mid-check, discard the check with no strobe.
REQ-022 SHALL, after rst_n deasserts with a_raw=1, treat it as a normal 0->1 change and emit rise.

Configuration
REQ-023 SHALL, with macro DEBOUNCE_SYNC_GLITCH_CNT_EN defined, expose glitch_cnt, incremented on every aborted check (CHK_HIGH->LOW or CHK_LOW->HIGH) and saturating at 255.
REQ-024 SHALL, without DEBOUNCE_SYNC_GLITCH_CNT_EN, remove the glitch_cnt port and its logic; all other behaviour is identical.

Structure
REQ-025 SHALL take the FSM state enum (debounce_state_t, 2 bits) and the glitch counter width constant from shared package debounce_pkg.
REQ-026 SHALL implement the synchronizer as sub-module sync_chain (parameter STAGES; ports clk, rst_n, d, q).

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover reset: hold rst_n=0 with a_raw=1 -> a=0, rise=0, fall=0, glitch_cnt=0 immediately, without a clock edge.
REQ-028 SHALL cover a clean rise: a_raw 0->1 held 10 cycles -> a=1 at edge 6 and rise=1 for that cycle only.
REQ-029 SHALL cover a rise glitch: a_raw=1 for 3 cycles, then 0 -> a stays 0, no rise, glitch_cnt=1.
REQ-030 SHALL cover a fall with bounce: from a=1, a_raw toggles 1-0-1-0 over 4 cycles, then holds 0 -> no change until stable, then a=0 after 6 edges, single fall pulse, glitch_cnt +1 per aborted check.
REQ-031 SHALL cover reset mid-check: rst_n pulsed low 2 cycles after a rising a_raw -> no rise; after release, rise 6 edges later.
REQ-032 SHALL cover glitch_cnt saturation: 300 three-cycle glitches -> glitch_cnt=255.
